password_checker: RTL

- Consumer end of the brute-force candidate stream: takes one candidate password per cycle over a valid/ready handshake and compares it to a target password.
- The target is loaded one character per cycle.
- Reports a match, latches the winning candidate and counts the attempts made; `found` is used upstream to drop the generator's enable.
- The compare path is a two-stage pipeline.

---
 rtl/password_checker_if.sv | 28 ++
 rtl/password_checker.sv | 107 ++++++++++
 2 files changed

// File: rtl/password_checker_if.sv
// Candidate-stream, target-load and result signals between the brute-force generator and the checker.
// The checker is the slave. The driver of the candidate stream and the target load is the master.
interface password_checker_if #(
  parameter int NUM_CHARS = 8,
  parameter int CHAR_W    = 8,
  parameter int CNT_W     = 32
);
  logic                          start_load;
  logic                          load_valid;
  logic [CHAR_W-1:0]             load_char;
  logic                          candidate_valid;
  logic [NUM_CHARS*CHAR_W-1:0]   candidate;
  logic                          candidate_ready;
  logic                          busy;
  logic                          found;
  logic [NUM_CHARS*CHAR_W-1:0]   match_password;
  logic [CNT_W-1:0]              attempts;

  modport master (
    output start_load, load_valid, load_char, candidate_valid, candidate,
    input  candidate_ready, busy, found, match_password, attempts
  );

  modport slave (
    input  start_load, load_valid, load_char, candidate_valid, candidate,
    output candidate_ready, busy, found, match_password, attempts
  );
endinterface

// File: rtl/password_checker.sv
// Compares a stream of candidate passwords against a target that is loaded one character at a time.
// The compare is two stages: register the per-character equality vector, then declare the match.
//
// state  | meaning
// IDLE   | waiting for start_load
// LOAD   | writing target characters, one per load_valid
// SEARCH | accepting candidates and comparing them to the target
// FOUND  | match reported; match_password and attempts are frozen
module password_checker #(
  parameter int NUM_CHARS = 8,
  parameter int CHAR_W    = 8,
  parameter int CNT_W     = 32
) (
  input logic           clock,
  input logic           reset,
  password_checker_if.slave bus
);
  localparam int PW_W  = NUM_CHARS * CHAR_W;
  localparam int IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, FOUND} state_t;

  state_t                           state, state_next;
  logic [IDX_W-1:0]                 load_idx;
  logic [NUM_CHARS-1:0][CHAR_W-1:0] target;
  logic [NUM_CHARS-1:0]             eq, s1_eq;
  logic [PW_W-1:0]                  s1_cand;
  logic                             s1_valid, s1_hit, accept, last_char;
  logic                             busy_q, found_q;
  logic [PW_W-1:0]                  match_q;
  logic [CNT_W-1:0]                 attempts_q;

  assign s1_hit    = s1_valid && (&s1_eq);
  assign last_char = (load_idx == IDX_W'(NUM_CHARS - 1));

  // Ready drops as soon as stage 1 holds a hit, so nothing is taken after the winner.
  assign bus.candidate_ready = (state == SEARCH) && !s1_hit;
  assign accept = bus.candidate_valid && bus.candidate_ready && !bus.start_load;

  assign bus.busy           = busy_q;
  assign bus.found          = found_q;
  assign bus.match_password = match_q;
  assign bus.attempts       = attempts_q;

  always_comb begin
    eq = '0;
    for (int i = 0; i < NUM_CHARS; i++)
      eq[i] = (bus.candidate[i*CHAR_W +: CHAR_W] == target[i]);
  end

  always_comb begin
    state_next = state;
    if (bus.start_load) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        LOAD:    if (bus.load_valid && last_char) state_next = SEARCH;
        SEARCH:  if (s1_hit) state_next = FOUND;
        FOUND:   state_next = FOUND;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q     <= 1'b0;
      found_q    <= 1'b0;
      load_idx   <= '0;
      target     <= '0;
      s1_valid   <= 1'b0;
      s1_eq      <= '0;
      s1_cand    <= '0;
      match_q    <= '0;
      attempts_q <= '0;
    end else begin
      busy_q  <= (state_next == LOAD) || (state_next == SEARCH);
      found_q <= (state_next == FOUND);
      if (bus.start_load) begin
        load_idx   <= '0;
        target     <= '0;
        s1_valid   <= 1'b0;
        s1_eq      <= '0;
        match_q    <= '0;
        attempts_q <= '0;
      end else begin
        if (state == LOAD && bus.load_valid) begin
          target[load_idx] <= bus.load_char;
          load_idx         <= load_idx + IDX_W'(1);
        end
        s1_valid <= accept;
        if (accept) begin
          s1_eq   <= eq;
          s1_cand <= bus.candidate;
          if (attempts_q != '1) attempts_q <= attempts_q + CNT_W'(1);
        end
        if (state == SEARCH && s1_hit) match_q <= s1_cand;
      end
    end
  end
endmodule
